// File: rtl/n_bit_down_counter_pkg.sv
// Shared types and constants for the loadable down-counter/timer.
// The state type is 2 bits wide so that the unused code can be
// recognised and steered back to a safe state.
package n_bit_down_counter_pkg;

   // Default bit width of the count, the load value and the step.
   localparam int DEFAULT_WIDTH = 3;

   // Counter phases. IDLE is the post-clear state. RUN means a countdown
   // is in progress. DONE means the count reached zero and is parked there.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // True when the state decodes to "counting".
   function automatic logic is_busy(input state_t s);
      return (s == ST_RUN);
   endfunction

   // True when the state decodes to "finished".
   function automatic logic is_done(input state_t s);
      return (s == ST_DONE);
   endfunction

endpackage

// File: rtl/n_bit_down_counter_if.sv
// Control and status bundle between the countdown unit and the logic that
// drives it. The master side loads a start value, supplies the step, and
// gates counting. The slave side is the counter itself.
interface n_bit_down_counter_if
   import n_bit_down_counter_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);

   // Synchronous load strobe and the value it loads.
   logic             LOAD;
   logic [WIDTH-1:0] D;

   // Amount subtracted per enabled cycle, and the count enable.
   logic [WIDTH-1:0] STEP;
   logic             EN;

   // Registered count and status flags.
   logic [WIDTH-1:0] F;
   logic             BUSY;
   logic             DONE;
   logic             BOUT;

   // Control logic view: drives commands and observes status.
   modport master (
      output LOAD, D, STEP, EN,
      input  F, BUSY, DONE, BOUT
   );

   // Counter view: consumes commands and produces status.
   modport slave (
      input  LOAD, D, STEP, EN,
      output F, BUSY, DONE, BOUT
   );

endinterface

// File: rtl/n_bit_subtractor.sv
// Unsigned WIDTH-bit subtractor with a borrow out. This is the
// subtracting counterpart of the n_bit_adder. S holds the low WIDTH bits
// of A-B. BOUT is set when B > A, meaning the true result went negative.
module n_bit_subtractor #(
   parameter int WIDTH = 3
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] S,
   output logic             BOUT
);

   // One extra bit at the top catches the borrow of the unsigned difference.
   logic [WIDTH:0] diff_wide;

   // Zero-extend both operands. The MSB of the difference is then exactly
   // the borrow out of the WIDTH-bit subtraction.
   always_comb begin
      diff_wide = {1'b0, A} - {1'b0, B};
   end

   assign S    = diff_wide[WIDTH-1:0];
   assign BOUT = diff_wide[WIDTH];

endmodule

// File: rtl/n_bit_down_counter.sv
// Loadable, step-decrementing countdown timer.
// A value is loaded. The count then drops by STEP on every enabled clock
// until it reaches zero, where it parks in DONE. An oversized final step
// never wraps: the count clamps to zero, and BOUT pulses for one cycle to
// report the clamp. All status outputs are flops, so no input reaches an
// output combinationally.
module n_bit_down_counter
   import n_bit_down_counter_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                 CLK,
   input  logic                 CLRN,
   n_bit_down_counter_if.slave  bus
);

   state_t           state_d, state_q;
   logic [WIDTH-1:0] f_d, f_q;
   logic             bout_d, bout_q;
   logic             busy_d, busy_q;
   logic             done_d, done_q;

   logic [WIDTH-1:0] sub_diff;
   logic             sub_borrow;

   // The next count candidate is always F - STEP. The FSM decides whether
   // to take it, clamp it, or ignore it.
   n_bit_subtractor #(
      .WIDTH (WIDTH)
   ) u_sub (
      .A    (f_q),
      .B    (bus.STEP),
      .S    (sub_diff),
      .BOUT (sub_borrow)
   );

   // Next-state logic. LOAD wins over everything and restarts from D.
   // Otherwise only RUN reacts to EN. IDLE and DONE simply hold.
   // BOUT defaults low, so it is high for the single cycle after a clamp.
   always_comb begin
      state_d = state_q;
      f_d     = f_q;
      bout_d  = 1'b0;

      if (bus.LOAD) begin
         f_d     = bus.D;
         state_d = (bus.D != '0) ? ST_RUN : ST_DONE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               state_d = ST_IDLE;
            end
            ST_RUN: begin
               if (bus.EN) begin
                  if (sub_borrow) begin
                     f_d     = '0;
                     bout_d  = 1'b1;
                     state_d = ST_DONE;
                  end else if (sub_diff == '0) begin
                     f_d     = '0;
                     state_d = ST_DONE;
                  end else begin
                     f_d     = sub_diff;
                     state_d = ST_RUN;
                  end
               end
            end
            ST_DONE: begin
               f_d     = '0;
               state_d = ST_DONE;
            end
            default: begin
               f_d     = '0;
               state_d = ST_IDLE;
            end
         endcase
      end

      busy_d = is_busy(state_d);
      done_d = is_done(state_d);
   end

   // State, count and flags are registered together, so BUSY/DONE/BOUT
   // change on the same edge as F. The clear is asynchronous: it forces
   // IDLE with a zero count as soon as CLRN falls.
   always_ff @(posedge CLK or negedge CLRN) begin
      if (!CLRN) begin
         state_q <= ST_IDLE;
         f_q     <= '0;
         bout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         f_q     <= f_d;
         bout_q  <= bout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.F    = f_q;
   assign bus.BUSY = busy_q;
   assign bus.DONE = done_q;
   assign bus.BOUT = bout_q;

endmodule
